// File: rtl/mod_addsub_sched_if.sv
// Bundle of requester, datapath and response signals for mod_addsub_sched.
// slave = the scheduler's view, master = producers/datapath/consumer side.
interface mod_addsub_sched_if #(
   parameter int W = 4
);
   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic         req0_sub;
   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic         req1_sub;
   logic [W-1:0] dp_a;
   logic [W-1:0] dp_b;
   logic         dp_sub;
   logic [W-1:0] dp_result;
   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [W-1:0] rsp_data;
   logic         busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sub,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_sub,
      output req1_ready,
      output dp_a, dp_b, dp_sub,
      input  dp_result,
      output rsp_valid, rsp_id, rsp_data,
      input  rsp_ready,
      output busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_sub,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_sub,
      input  req1_ready,
      input  dp_a, dp_b, dp_sub,
      output dp_result,
      input  rsp_valid, rsp_id, rsp_data,
      output rsp_ready,
      input  busy
   );
endinterface

// File: rtl/mod_addsub_sched.sv
// Two-requester scheduler for a shared combinational modular add/sub datapath.
// MODADD_SCHED_RR_EN selects round-robin arbitration; default is fixed priority (req0 wins).
module mod_addsub_sched #(
   parameter int W             = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input logic               clk,
   input logic               rst_n,
   mod_addsub_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

   // Loaded with SETTLE_CYCLES so the capture edge lands SETTLE_CYCLES+1 edges after transfer.
   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES);

   state_t       state;
   logic [3:0]   cnt;
   logic         id;
   logic         last_grant;
   logic         grant;
   logic [W-1:0] dp_a_q;
   logic [W-1:0] dp_b_q;
   logic         dp_sub_q;
   logic         rsp_valid_q;
   logic         rsp_id_q;
   logic [W-1:0] rsp_data_q;
   logic         busy_q;
   logic         ready0;
   logic         ready1;

`ifdef MODADD_SCHED_RR_EN
   always_comb begin
      grant = 1'b0;
      if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
      else if (bus.req1_valid)              grant = 1'b1;
   end
`else
   always_comb begin
      grant = 1'b0;
      if (!bus.req0_valid && bus.req1_valid) grant = 1'b1;
   end

   // Tracked for parity with the round-robin build; fixed priority ignores it.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   assign ready0 = (state == IDLE) && bus.req0_valid && !grant;
   assign ready1 = (state == IDLE) && bus.req1_valid &&  grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         id          <= 1'b0;
         last_grant  <= 1'b1;
         dp_a_q      <= '0;
         dp_b_q      <= '0;
         dp_sub_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ready0 || ready1) begin
                  dp_a_q     <= ready1 ? bus.req1_a   : bus.req0_a;
                  dp_b_q     <= ready1 ? bus.req1_b   : bus.req0_b;
                  dp_sub_q   <= ready1 ? bus.req1_sub : bus.req0_sub;
                  id         <= ready1;
                  last_grant <= ready1;
                  cnt        <= CNT_INIT;
                  state      <= SETTLE;
                  busy_q     <= 1'b1;
               end
            end
            SETTLE: begin
               if (cnt == 4'd0) begin
                  rsp_data_q  <= bus.dp_result;
                  rsp_id_q    <= id;
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.dp_a       = dp_a_q;
   assign bus.dp_b       = dp_b_q;
   assign bus.dp_sub     = dp_sub_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mod_addsub_sched.sv
// Directed bench for mod_addsub_sched: vector table plus arbitration, back-pressure,
// mid-operation reset and settle-latency sequences against a (a+-b) mod 15 datapath model.
module tb_mod_addsub_sched;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   mod_addsub_sched_if #(.W(4)) bus   ();
   mod_addsub_sched_if #(.W(4)) bus1  ();
   mod_addsub_sched_if #(.W(4)) bus15 ();

   mod_addsub_sched #(.W(4), .SETTLE_CYCLES(2))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
   mod_addsub_sched #(.W(4), .SETTLE_CYCLES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
   mod_addsub_sched #(.W(4), .SETTLE_CYCLES(15)) dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

   function automatic logic [3:0] model(input logic [3:0] a, input logic [3:0] b, input logic s);
      int t;
      t = s ? (int'(a) - int'(b)) : (int'(a) + int'(b));
      t = ((t % 15) + 15) % 15;
      return 4'(t);
   endfunction

   assign bus.dp_result   = model(bus.dp_a,   bus.dp_b,   bus.dp_sub);
   assign bus1.dp_result  = model(bus1.dp_a,  bus1.dp_b,  bus1.dp_sub);
   assign bus15.dp_result = model(bus15.dp_a, bus15.dp_b, bus15.dp_sub);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         req;
      logic [3:0] a;
      logic [3:0] b;
      logic       sub;
      logic [3:0] exp_data;
      int         hold;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_op(input int req, input logic [3:0] a, input logic [3:0] b,
                        input logic sub, input logic [3:0] exp_d, input int hold);
      int lat;
      @(negedge clk);
      if (req == 0) begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
      end
      #1;
      check("req0_ready", int'(bus.req0_ready), int'(req == 0));
      check("req1_ready", int'(bus.req1_ready), int'(req == 1));
      @(posedge clk);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      check("busy_settle", int'(bus.busy), 1);
      check("dp_a", int'(bus.dp_a), int'(a));
      check("dp_b", int'(bus.dp_b), int'(b));
      check("dp_sub", int'(bus.dp_sub), int'(sub));
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!bus.rsp_valid && lat < 40);
      check("latency", lat, 3);
      check("rsp_data", int'(bus.rsp_data), int'(exp_d));
      check("rsp_id", int'(bus.rsp_id), req);
      check("dp_a_held", int'(bus.dp_a), int'(a));
      check("dp_sub_held", int'(bus.dp_sub), int'(sub));
      if (hold > 0) begin
         bus.req0_valid = 1'b1;
         bus.req1_valid = 1'b1;
         for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_rsp_valid", int'(bus.rsp_valid), 1);
            check("bp_rsp_data", int'(bus.rsp_data), int'(exp_d));
            check("bp_rsp_id", int'(bus.rsp_id), req);
            check("bp_busy", int'(bus.busy), 1);
            check("bp_ready0", int'(bus.req0_ready), 0);
            check("bp_ready1", int'(bus.req1_ready), 0);
            check("bp_dp_b", int'(bus.dp_b), int'(b));
         end
         bus.req0_valid = 1'b0;
         bus.req1_valid = 1'b0;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("rsp_valid_drop", int'(bus.rsp_valid), 0);
      check("busy_idle", int'(bus.busy), 0);
   endtask

   initial begin
      int   ids[4];
      int   n_rsp;
      int   lat1;
      int   lat15;
      logic stale;

      n_checks = 0;
      n_errors = 0;
      vecs[0] = '{req: 0, a: 4'd9,  b: 4'd8,  sub: 1'b0, exp_data: 4'd2,  hold: 0};
      vecs[1] = '{req: 1, a: 4'd3,  b: 4'd5,  sub: 1'b1, exp_data: 4'd13, hold: 10};
      vecs[2] = '{req: 0, a: 4'd7,  b: 4'd7,  sub: 1'b1, exp_data: 4'd0,  hold: 0};
      vecs[3] = '{req: 1, a: 4'd15, b: 4'd15, sub: 1'b0, exp_data: 4'd0,  hold: 0};
      vecs[4] = '{req: 0, a: 4'd0,  b: 4'd1,  sub: 1'b1, exp_data: 4'd14, hold: 0};
      vecs[5] = '{req: 1, a: 4'd14, b: 4'd0,  sub: 1'b0, exp_data: 4'd14, hold: 0};

      rst_n = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
      bus.rsp_ready  = 1'b0;
      bus1.req0_valid = 1'b0; bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_sub = 1'b0;
      bus1.req1_valid = 1'b0; bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_sub = 1'b0;
      bus1.rsp_ready  = 1'b0;
      bus15.req0_valid = 1'b0; bus15.req0_a = '0; bus15.req0_b = '0; bus15.req0_sub = 1'b0;
      bus15.req1_valid = 1'b0; bus15.req1_a = '0; bus15.req1_b = '0; bus15.req1_sub = 1'b0;
      bus15.rsp_ready  = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_dp_a", int'(bus.dp_a), 0);
      check("rst_dp_b", int'(bus.dp_b), 0);
      check("rst_dp_sub", int'(bus.dp_sub), 0);
      check("rst_rsp_valid", int'(bus.rsp_valid), 0);
      check("rst_rsp_id", int'(bus.rsp_id), 0);
      check("rst_rsp_data", int'(bus.rsp_data), 0);
      check("rst_busy", int'(bus.busy), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++)
         do_op(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp_data, vecs[i].hold);

      // Tie arbitration from a fresh reset.
      do_reset();
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd1; bus.req0_sub = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 4'd2; bus.req1_sub = 1'b0;
      bus.rsp_ready  = 1'b1;
      n_rsp = 0;
      for (int c = 0; c < 100 && n_rsp < 4; c++) begin
         @(posedge clk);
         @(negedge clk);
         check("one_ready", int'(bus.req0_ready && bus.req1_ready), 0);
         if (bus.rsp_valid) begin
            ids[n_rsp] = int'(bus.rsp_id);
            check("tie_data", int'(bus.rsp_data), bus.rsp_id ? 4 : 2);
            n_rsp++;
         end
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      check("tie_count", n_rsp, 4);
`ifdef MODADD_SCHED_RR_EN
      check("tie_id0", ids[0], 0);
      check("tie_id1", ids[1], 1);
      check("tie_id2", ids[2], 0);
      check("tie_id3", ids[3], 1);
`else
      check("tie_id0", ids[0], 0);
      check("tie_id1", ids[1], 0);
      check("tie_id2", ids[2], 0);
      check("tie_id3", ids[3], 0);
`endif
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("tie_idle", int'(bus.busy), 0);

      // Reset asserted during SETTLE.
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_a = 4'd5; bus.req0_b = 4'd4; bus.req0_sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      check("mid_busy_before", int'(bus.busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rsp_valid", int'(bus.rsp_valid), 0);
      check("mid_busy", int'(bus.busy), 0);
      check("mid_dp_a", int'(bus.dp_a), 0);
      check("mid_dp_b", int'(bus.dp_b), 0);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.rsp_valid) stale = 1'b1;
      end
      check("no_stale_rsp", int'(stale), 0);
      do_op(0, 4'd5, 4'd4, 1'b0, 4'd9, 0);

      // Settle latency sweep on the SETTLE_CYCLES=1 and 15 instances.
      @(negedge clk);
      bus1.req0_valid  = 1'b1; bus1.req0_a  = 4'd6; bus1.req0_b  = 4'd4; bus1.req0_sub  = 1'b1;
      bus15.req0_valid = 1'b1; bus15.req0_a = 4'd6; bus15.req0_b = 4'd4; bus15.req0_sub = 1'b1;
      #1;
      check("s1_ready", int'(bus1.req0_ready), 1);
      check("s15_ready", int'(bus15.req0_ready), 1);
      @(posedge clk);
      @(negedge clk);
      bus1.req0_valid  = 1'b0;
      bus15.req0_valid = 1'b0;
      lat1  = 0;
      lat15 = 0;
      for (int e = 1; e <= 25; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus1.rsp_valid && lat1 == 0)   lat1  = e;
         if (bus15.rsp_valid && lat15 == 0) lat15 = e;
      end
      check("s1_latency", lat1, 2);
      check("s15_latency", lat15, 16);
      check("s1_data", int'(bus1.rsp_data), 2);
      check("s15_data", int'(bus15.rsp_data), 2);
      bus1.rsp_ready  = 1'b1;
      bus15.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.rsp_ready  = 1'b0;
      bus15.rsp_ready = 1'b0;
      check("s1_idle", int'(bus1.busy), 0);
      check("s15_idle", int'(bus15.busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
